serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder with carry-in that processes one bit per clock, LSB first. Each bit is added by a full-add slice made from two instances of the team's `structural_adder` half-adder cell plus an OR on the two carries. The block sits directly downstream of the half-adder cell and turns it into a multi-bit, handshaked arithmetic stage. Operands enter through a valid/ready start port, and the result leaves through a valid/ready result port.

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in, one bit per clock, LSB first.
// Latency: result_valid rises WIDTH cycles after the start accept edge; minimum period WIDTH+2.
// Backpressure: result held stable in DONE until result_ready; start_ready low outside IDLE.

// Half-adder cell: sum and carry of two single bits.
module structural_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-add slice: two half adders chained, carries merged by OR.
    logic s0, c0, s1, c1;

    structural_adder u_ha0 (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .s_o (s0),
        .c_o (c0)
    );

    structural_adder u_ha1 (
        .a_i (s0),
        .b_i (carry_q),
        .s_o (s1),
        .c_o (c1)
    );

    // Next-state and datapath updates; the handshake outputs depend only on state.
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift right and insert the new bit at the MSB; works for WIDTH==1 too.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = s1;
                a_sr_d           = a_sr_q >> 1;
                b_sr_d           = b_sr_q >> 1;
                carry_d          = c0 | c1;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result is shown straight from the registers, so it persists after DONE.
    assign sum  = sum_q;
    assign cout = carry_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8.
// Latency: checks result_valid exactly 8 cycles after accept and 10-cycle back-to-back period.
// Backpressure: holds result_ready low in DONE while offering new operands.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .cout         (cout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE; returns result, latency and busy count.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic rr, output logic [W-1:0] s, output logic co,
                          output int lat, output int busy_cnt, output logic sr_after);
        a = ta; b = tb; cin = tc;
        start_valid  = 1'b1;
        result_ready = rr;
        step();
        start_valid = 1'b0;
        sr_after = start_ready;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!result_valid && lat < 40) begin
            step();
            lat++;
            busy_cnt += busy ? 1 : 0;
        end
        s  = sum;
        co = cout;
        if (rr) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step();
        step();
        n_checks++;
        if ({start_ready, result_valid, sum, cout, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: sr=%b rv=%b sum=%h cout=%b busy=%b, required 1 0 00 0 0",
                     start_ready, result_valid, sum, cout, busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic co, sr; int lat, bc;
        run_op(8'h3C, 8'h0F, 1'b0, 1'b1, s, co, lat, bc, sr);
        n_checks++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles, required 8", lat);
        end
        n_checks++;
        if ({co, s} !== {1'b0, 8'h4B}) begin
            n_fail++; $display("FAIL basic_sum: got cout=%b sum=%h, required 0 4b", co, s);
        end
        n_checks++;
        if (bc !== 9) begin
            n_fail++; $display("FAIL basic_busy: busy for %0d cycles, required 9", bc);
        end
        n_checks++;
        if (sr !== 1'b0) begin
            n_fail++; $display("FAIL basic_start_ready_run: got %b, required 0", sr);
        end
        n_checks++;
        if ({busy, start_ready, result_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL basic_return_idle: busy=%b sr=%b rv=%b, required 0 1 0",
                     busy, start_ready, result_valid);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
        logic         vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [3] = '{8'h00, 8'hFF, 8'h01};
        logic         ec [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0] s; logic co, sr; int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b1, s, co, lat, bc, sr);
            n_checks++;
            if ({co, s} !== {ec[i], es[i]}) begin
                n_fail++;
                $display("FAIL wrap_%0d: got cout=%b sum=%h, required %b %h", i, co, s, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s; logic co, sr; int lat, bc;
        run_op(8'h81, 8'h81, 1'b0, 1'b0, s, co, lat, bc, sr);
        n_checks++;
        if ({co, s} !== {1'b1, 8'h02}) begin
            n_fail++; $display("FAIL bp_sum: got cout=%b sum=%h, required 1 02", co, s);
        end
        for (int i = 0; i < 5; i++) begin
            start_valid = (i % 2 == 0);
            a = 8'hFF; b = 8'hFF; cin = 1'b1;
            step();
            n_checks++;
            if ({result_valid, start_ready, cout, sum} !== {1'b1, 1'b0, 1'b1, 8'h02}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: rv=%b sr=%b cout=%b sum=%h, required 1 0 1 02",
                         i, result_valid, start_ready, cout, sum);
            end
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        step();
        n_checks++;
        if ({result_valid, start_ready, busy, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h02}) begin
            n_fail++;
            $display("FAIL bp_release: rv=%b sr=%b busy=%b cout=%b sum=%h, required 0 1 0 1 02",
                     result_valid, start_ready, busy, cout, sum);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s; logic co, sr; int lat, bc;
        int seen = 0;
        a = 8'hAA; b = 8'h55; cin = 1'b0;
        start_valid = 1'b1; result_ready = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, start_ready, result_valid, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b sr=%b rv=%b cout=%b sum=%h, required 0 1 0 0 00",
                     busy, start_ready, result_valid, cout, sum);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (result_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midreset_no_valid: result_valid seen %0d cycles, required 0", seen);
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b1, s, co, lat, bc, sr);
        n_checks++;
        if ({co, s, lat} !== {1'b0, 8'h46, 32'd8}) begin
            n_fail++;
            $display("FAIL midreset_next: cout=%b sum=%h lat=%0d, required 0 46 8", co, s, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{8'hC8, 8'h7F, 8'hF0};
        logic [W-1:0] vb [3] = '{8'h64, 8'h01, 8'h0F};
        logic         vc [3] = '{1'b0, 1'b1, 1'b1};
        int acc_cyc [3];
        int cyc = 0, acc_idx = 0, res_idx = 0;
        logic sr;
        logic [W:0] expv;
        a = va[0]; b = vb[0]; cin = vc[0];
        start_valid = 1'b1; result_ready = 1'b1;
        while (res_idx < 3 && cyc < 100) begin
            sr = start_ready;
            step();
            cyc++;
            if (sr && acc_idx < 3) begin
                acc_cyc[acc_idx] = cyc;
                acc_idx++;
                if (acc_idx < 3) begin
                    a = va[acc_idx]; b = vb[acc_idx]; cin = vc[acc_idx];
                end else begin
                    start_valid = 1'b0;
                end
            end
            if (result_valid) begin
                expv = {1'b0, va[res_idx]} + {1'b0, vb[res_idx]} + {8'h00, vc[res_idx]};
                n_checks++;
                if ({cout, sum} !== expv) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: got cout=%b sum=%h, required %b %h",
                             res_idx, cout, sum, expv[W], expv[W-1:0]);
                end
                res_idx++;
            end
        end
        start_valid = 1'b0;
        n_checks++;
        if (res_idx !== 3 || acc_idx !== 3) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d accepts %0d results, required 3 3", acc_idx, res_idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 10) begin
                    n_fail++;
                    $display("FAIL b2b_period_%0d: got %0d cycles, required 10",
                             i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
